oclib_axim_credit_fifo: RTL and testbench
=========================================

# oclib_axim_credit_fifo

Parametrised AXI4 master-side buffer and the successor to the plain per-channel AXI master FIFO. It places a FIFO on each of AR, AW, W, R and B, and adds three flow-control behaviours:
- store-and-forward write gating, so AW is never issued ahead of its complete W burst;
- read-credit gating, so every issued AR has guaranteed R buffer space and the slave is never back-pressured on R;
- a cap on outstanding write and read transactions.

It sits between an AXI4 master and an interconnect or memory controller, where a stalled slave-side channel must not block the fabric.

## Interface
Parameters:
- AximType, default oclib_pkg::axi4m_256_s: master-to-slave bundle (ar/aw/w payloads plus valids, rready, bready)
- AximFbType, default oclib_pkg::axi4m_256_fb_s: slave-to-master bundle (r/b payloads plus valids, arready, awready, wready)
- ArDepth, default 16: AR FIFO entries
- AwDepth, default 16: AW FIFO entries
- WDepth, default 512: W FIFO beats; must be ≥ MaxBurst
- RDepth, default 512: R FIFO beats; must be ≥ MaxBurst
- BDepth, default MaxWrOutstanding: B FIFO entries; must be ≥ MaxWrOutstanding
- MaxBurst, default 256: largest arlen+1 / awlen+1 accepted
- MaxWrOutstanding, default 16: issued AW not yet returned on B
- MaxRdOutstanding, default 16: issued AR with rlast not yet delivered upstream
- StoreForward, default 1: 1 enables AW gating; 0 forwards AW as soon as it is buffered

Ports:
- clock, input, 1: sole clock
- reset, input, 1: asynchronous, active-low reset
- in, input, AximType: from master
- inFb, output, AximFbType: to master
- out, output, AximType: to slave
- outFb, input, AximFbType: from slave
- rCredits, output, $clog2(RDepth+1): free, unreserved R FIFO beats
- wrOutstanding, output, $clog2(MaxWrOutstanding+1): AW issued minus B delivered
- rdOutstanding, output, $clog2(MaxRdOutstanding+1): AR issued minus rlast delivered
- wBursts, output, $clog2(WDepth+1): complete W bursts buffered whose AW has not been issued

## Operation
- **All FIFOs:** valid/ready handshake; a transfer occurs when valid && ready on a rising clock edge. Payloads are never reordered.
- **wBursts:**
  - +1 on an upstream W handshake with wlast;
  - −1 on an out.aw handshake;
  - both in the same cycle: net 0.
- **AW gate (StoreForward=1):** out.awvalid = AW FIFO valid && wBursts>0 && wrOutstanding<MaxWrOutstanding.
- **AW gate (StoreForward=0):** the wBursts term is dropped.
- **W:** out.wvalid is ungated. The slave may accept W before AW, as AXI4 allows.
- **rCredits:**
  - reset value is RDepth;
  - out.ar handshake subtracts arlen+1;
  - each upstream R handshake (inFb.rvalid && in.rready) adds 1;
  - both in the same cycle: rCredits − (arlen+1) + 1.
- **AR gate:** out.arvalid = AR FIFO valid && rCredits ≥ arlen+1 && rdOutstanding < MaxRdOutstanding.
- **R and B back-pressure:** out.rready = 1 and out.bready = 1 at all times. Credits and caps guarantee the R and B FIFOs cannot overflow.
- **Overflow check:** if either FIFO is ever full while the slave asserts valid, raise an assertion error (simulation only).
- **wrOutstanding:** +1 on an out.aw handshake, −1 on an upstream B handshake.
- **rdOutstanding:** +1 on an out.ar handshake, −1 on an upstream R handshake with rlast. Simultaneous events net out.
- **Length violations:** arlen+1 > MaxBurst is a master protocol violation, flagged by assertion. Behaviour is undefined.

## Timing
- **Reset (asserted low, asynchronous):** all FIFOs empty, rCredits=RDepth, all other counters 0.
- **Outputs during reset:** all valids and readys low, except out.rready = out.bready = 1.
- **Reset mid-burst:** all in-flight data is discarded, with no recovery. Release is synchronised internally so all sub-blocks leave reset on the same edge.
- **Gate timing:** all counters are registered. Gates are combinational on the counter registers and the FIFO output valids.
- **AW issue latency:** earliest out.awvalid is one cycle after the wlast handshake.
- **AR issue latency:** earliest out.arvalid is one cycle after sufficient credit returns.
- **Pass-through latency:** FIFO latency is the oclib_fifo latency. Gating adds no pipeline stages.
- **Stability:** once out.awvalid or out.arvalid is asserted, it is held with the payload stable until the handshake. Counters only move toward satisfying the gate while waiting.

## Structure
- Axi4 bundle types and burst-length helpers belong in oclib_pkg. No new types are needed beyond a credit-width localparam.
- Five oclib_fifo instances.
- One natural sub-module, oclib_credit_counter:
  - parameters Width and Init;
  - ports: reserve amount, reserve strobe, return strobe, count output;
  - instantiated for rCredits, wrOutstanding, rdOutstanding and wBursts.

## Test plan
1. **Write gating:** StoreForward=1; AW (awlen=3) presented first, W beats 1–3 held back → out.awvalid stays 0. 4th beat (wlast) accepted → out.awvalid=1 the next cycle.
2. **Read credit:** RDepth=16, in.rready=0, AR arlen=15 issued (rCredits 16→0) → second AR (arlen=0) stalls. Single R beat drained → rCredits=1, second AR issues the next cycle.
3. **Simultaneous reserve and return:** rCredits=8; out.ar handshake with arlen=3 in the same cycle as an upstream R handshake → rCredits=5.
4. **Outstanding cap:** MaxWrOutstanding=2, slave withholds B → third AW stalls with wrOutstanding=2. One B delivered upstream → third AW issues.
5. **Reset mid-operation:** reset pulsed low mid read burst → all valids 0 immediately, rCredits=RDepth, counters 0. After release, a fresh AR completes normally.
6. **StoreForward=0:** AW with no W beats → out.awvalid=1 one FIFO latency after acceptance.

Source files
------------

// File: rtl/oclib_axim_credit_fifo_pkg.sv
// Constants local to the credit-gated AXI master buffer.
package oclib_axim_credit_fifo_pkg;

  localparam int BeatWidth = 9;

endpackage

// File: rtl/oclib_pkg.sv
// Shared AXI4 bundle types and burst helpers used across the oclib blocks.
package oclib_pkg;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } axi4_a_s;

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  strb;
    logic         last;
  } axi4_256_w_s;

  typedef struct packed {
    logic [3:0]   id;
    logic [255:0] data;
    logic [1:0]   resp;
    logic         last;
  } axi4_256_r_s;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } axi4_b_s;

  typedef struct packed {
    axi4_a_s     ar;
    logic        arvalid;
    axi4_a_s     aw;
    logic        awvalid;
    axi4_256_w_s w;
    logic        wvalid;
    logic        rready;
    logic        bready;
  } axi4m_256_s;

  typedef struct packed {
    axi4_256_r_s r;
    logic        rvalid;
    axi4_b_s     b;
    logic        bvalid;
    logic        arready;
    logic        awready;
    logic        wready;
  } axi4m_256_fb_s;

  // Beats in a burst (len+1), wide enough for len=255.
  function automatic logic [8:0] axi4BurstBeats(input logic [7:0] len);
    return {1'b0, len} + 9'd1;
  endfunction

endpackage

// File: rtl/oclib_credit_counter.sv
// Registered up/down counter: reserve subtracts an amount, return adds one.
module oclib_credit_counter #(
  parameter int Width = 8,
  parameter int Init  = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [Width-1:0] reserveAmount,
  input  logic             reserveStrobe,
  input  logic             returnStrobe,
  output logic [Width-1:0] count
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count <= Width'(Init);
    else        count <= count - (reserveStrobe ? reserveAmount : '0) + Width'(returnStrobe);
  end

endmodule

// File: rtl/oclib_fifo.sv
// Show-ahead synchronous FIFO; a written entry is visible on the output one cycle later.
module oclib_fifo #(
  parameter int Width = 8,
  parameter int Depth = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [Width-1:0] inData,
  input  logic             inValid,
  output logic             inReady,
  output logic [Width-1:0] outData,
  output logic             outValid,
  input  logic             outReady
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wrPtr;
  logic [PtrW-1:0]  rdPtr;
  logic [CntW-1:0]  count;
  logic             push;
  logic             pop;

  function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Ready is held low while in reset so nothing is accepted before release.
  assign inReady  = reset && (count != CntW'(Depth));
  assign outValid = (count != '0);
  assign outData  = mem[rdPtr];
  assign push     = inValid && inReady;
  assign pop      = outValid && outReady;

  always_ff @(posedge clock) begin
    if (push) mem[wrPtr] <= inData;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= nextPtr(wrPtr);
      if (pop)  rdPtr <= nextPtr(rdPtr);
      count <= count + CntW'(push) - CntW'(pop);
    end
  end

endmodule

// File: rtl/oclib_axim_credit_fifo.sv
// AXI4 master-side buffer with per-channel FIFOs, store-and-forward AW gating,
// R credit gating and outstanding-transaction caps.
module oclib_axim_credit_fifo
  import oclib_pkg::*;
  import oclib_axim_credit_fifo_pkg::*;
#(
  parameter type AximType         = oclib_pkg::axi4m_256_s,
  parameter type AximFbType       = oclib_pkg::axi4m_256_fb_s,
  parameter int  MaxBurst         = 256,
  parameter int  MaxWrOutstanding = 16,
  parameter int  MaxRdOutstanding = 16,
  parameter int  ArDepth          = 16,
  parameter int  AwDepth          = 16,
  parameter int  WDepth           = 512,
  parameter int  RDepth           = 512,
  parameter int  BDepth           = MaxWrOutstanding,
  parameter int  StoreForward     = 1
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  AximType                               in,
  output AximFbType                             inFb,
  output AximType                               out,
  input  AximFbType                             outFb,
  output logic [$clog2(RDepth+1)-1:0]           rCredits,
  output logic [$clog2(MaxWrOutstanding+1)-1:0] wrOutstanding,
  output logic [$clog2(MaxRdOutstanding+1)-1:0] rdOutstanding,
  output logic [$clog2(WDepth+1)-1:0]           wBursts
);

  localparam int CreditW  = $clog2(RDepth + 1);
  localparam int WrOutW   = $clog2(MaxWrOutstanding + 1);
  localparam int RdOutW   = $clog2(MaxRdOutstanding + 1);
  localparam int WBurstW  = $clog2(WDepth + 1);

  logic [1:0] rstSync;
  logic       rstN;

  axi4_a_s     arData, awData;
  axi4_256_w_s wData;
  axi4_256_r_s rData;
  axi4_b_s     bData;

  logic arInReady, awInReady, wInReady, rInReady, bInReady;
  logic arQValid, awQValid, wQValid, rQValid, bQValid;
  logic arGate, awGate, arFire, awFire;
  logic wlastIn, rUp, rlastUp, bUp;
  logic [BeatWidth-1:0] arBeats;

  // Assert asynchronously, release on a common edge for every sub-block.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rstSync <= 2'b00;
    else        rstSync <= {rstSync[0], 1'b1};
  end
  assign rstN = rstSync[1];

  assign arBeats = axi4BurstBeats(arData.len);
  assign arGate  = (int'(rCredits) >= int'(arBeats)) &&
                   (int'(rdOutstanding) < MaxRdOutstanding);
  assign awGate  = ((StoreForward == 0) || (wBursts != '0)) &&
                   (int'(wrOutstanding) < MaxWrOutstanding);
  assign arFire  = arQValid && arGate && outFb.arready;
  assign awFire  = awQValid && awGate && outFb.awready;
  assign wlastIn = in.wvalid && wInReady && in.w.last;
  assign rUp     = rQValid && in.rready;
  assign rlastUp = rUp && rData.last;
  assign bUp     = bQValid && in.bready;

  oclib_fifo #(.Width($bits(axi4_a_s)), .Depth(ArDepth)) arFifo (
    .clock(clock), .reset(rstN),
    .inData(in.ar), .inValid(in.arvalid), .inReady(arInReady),
    .outData(arData), .outValid(arQValid), .outReady(arGate && outFb.arready));

  oclib_fifo #(.Width($bits(axi4_a_s)), .Depth(AwDepth)) awFifo (
    .clock(clock), .reset(rstN),
    .inData(in.aw), .inValid(in.awvalid), .inReady(awInReady),
    .outData(awData), .outValid(awQValid), .outReady(awGate && outFb.awready));

  oclib_fifo #(.Width($bits(axi4_256_w_s)), .Depth(WDepth)) wFifo (
    .clock(clock), .reset(rstN),
    .inData(in.w), .inValid(in.wvalid), .inReady(wInReady),
    .outData(wData), .outValid(wQValid), .outReady(outFb.wready));

  oclib_fifo #(.Width($bits(axi4_256_r_s)), .Depth(RDepth)) rFifo (
    .clock(clock), .reset(rstN),
    .inData(outFb.r), .inValid(outFb.rvalid), .inReady(rInReady),
    .outData(rData), .outValid(rQValid), .outReady(in.rready));

  oclib_fifo #(.Width($bits(axi4_b_s)), .Depth(BDepth)) bFifo (
    .clock(clock), .reset(rstN),
    .inData(outFb.b), .inValid(outFb.bvalid), .inReady(bInReady),
    .outData(bData), .outValid(bQValid), .outReady(in.bready));

  oclib_credit_counter #(.Width(CreditW), .Init(RDepth)) rCreditCounter (
    .clock(clock), .reset(rstN),
    .reserveAmount(CreditW'(arBeats)), .reserveStrobe(arFire),
    .returnStrobe(rUp), .count(rCredits));

  // Outstanding counters count issue on the return strobe and completion on reserve.
  oclib_credit_counter #(.Width(WrOutW), .Init(0)) wrOutCounter (
    .clock(clock), .reset(rstN),
    .reserveAmount(WrOutW'(1)), .reserveStrobe(bUp),
    .returnStrobe(awFire), .count(wrOutstanding));

  oclib_credit_counter #(.Width(RdOutW), .Init(0)) rdOutCounter (
    .clock(clock), .reset(rstN),
    .reserveAmount(RdOutW'(1)), .reserveStrobe(rlastUp),
    .returnStrobe(arFire), .count(rdOutstanding));

  oclib_credit_counter #(.Width(WBurstW), .Init(0)) wBurstCounter (
    .clock(clock), .reset(rstN),
    .reserveAmount(WBurstW'(1)), .reserveStrobe(awFire),
    .returnStrobe(wlastIn), .count(wBursts));

  always_comb begin
    out         = '0;
    out.ar      = arData;
    out.arvalid = arQValid && arGate;
    out.aw      = awData;
    out.awvalid = awQValid && awGate;
    out.w       = wData;
    out.wvalid  = wQValid;
    out.rready  = 1'b1;
    out.bready  = 1'b1;
  end

  always_comb begin
    inFb         = '0;
    inFb.r       = rData;
    inFb.rvalid  = rQValid;
    inFb.b       = bData;
    inFb.bvalid  = bQValid;
    inFb.arready = arInReady;
    inFb.awready = awInReady;
    inFb.wready  = wInReady;
  end

`ifndef SYNTHESIS
  // R and B are never back-pressured, so a full FIFO here means lost data.
  rNoOverflow: assert property (@(posedge clock) disable iff (!rstN)
    outFb.rvalid |-> rInReady) else $error("R FIFO overflow");
  bNoOverflow: assert property (@(posedge clock) disable iff (!rstN)
    outFb.bvalid |-> bInReady) else $error("B FIFO overflow");
  arLenLegal: assert property (@(posedge clock) disable iff (!rstN)
    in.arvalid |-> int'(axi4BurstBeats(in.ar.len)) <= MaxBurst) else $error("arlen exceeds MaxBurst");
  awLenLegal: assert property (@(posedge clock) disable iff (!rstN)
    in.awvalid |-> int'(axi4BurstBeats(in.aw.len)) <= MaxBurst) else $error("awlen exceeds MaxBurst");
`endif

endmodule

// File: tb/tb_oclib_axim_credit_fifo.sv
// Scoreboarded bench for oclib_axim_credit_fifo: gating, credits, caps and reset.
module tb_oclib_axim_credit_fifo;
  import oclib_pkg::*;

  localparam int RDepth = 16;
  localparam int WDepth = 16;
  localparam int MaxWr  = 2;
  localparam int MaxRd  = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;

  axi4m_256_s    in, out, out2;
  axi4m_256_fb_s inFb, outFb, inFb2;

  logic [$clog2(RDepth+1)-1:0] rCredits, rCredits2;
  logic [$clog2(MaxWr+1)-1:0]  wrOutstanding, wrOutstanding2;
  logic [$clog2(MaxRd+1)-1:0]  rdOutstanding, rdOutstanding2;
  logic [$clog2(WDepth+1)-1:0] wBursts, wBursts2;

  int assertionCount = 0;
  int failCount      = 0;

  logic [63:0] arQ[$];
  logic [63:0] awQ[$];
  logic [63:0] wQ[$];
  logic [63:0] bQ[$];
  logic [64:0] rQ[$];
  logic [64:0] rExp;

  always #5 clock = ~clock;

  oclib_axim_credit_fifo #(
    .MaxBurst(16), .MaxWrOutstanding(MaxWr), .MaxRdOutstanding(MaxRd),
    .ArDepth(4), .AwDepth(4), .WDepth(WDepth), .RDepth(RDepth), .BDepth(MaxWr),
    .StoreForward(1)
  ) dut (
    .clock(clock), .reset(reset), .in(in), .inFb(inFb), .out(out), .outFb(outFb),
    .rCredits(rCredits), .wrOutstanding(wrOutstanding),
    .rdOutstanding(rdOutstanding), .wBursts(wBursts));

  // Same stimulus, AW forwarded without waiting for W data.
  oclib_axim_credit_fifo #(
    .MaxBurst(16), .MaxWrOutstanding(MaxWr), .MaxRdOutstanding(MaxRd),
    .ArDepth(4), .AwDepth(4), .WDepth(WDepth), .RDepth(RDepth), .BDepth(MaxWr),
    .StoreForward(0)
  ) dutNoSf (
    .clock(clock), .reset(reset), .in(in), .inFb(inFb2), .out(out2), .outFb(outFb),
    .rCredits(rCredits2), .wrOutstanding(wrOutstanding2),
    .rdOutstanding(rdOutstanding2), .wBursts(wBursts2));

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assertionCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic applyStimulusAr(input logic [63:0] addr, input logic [7:0] len);
    int n = 0;
    in.ar = '0; in.ar.addr = addr; in.ar.len = len; in.arvalid = 1'b1;
    arQ.push_back(addr);
    while (!inFb.arready && n < 20) begin tick(); n++; end
    checkOutput("arAccept", 64'(inFb.arready), 64'd1);
    tick();
    in.arvalid = 1'b0;
  endtask

  task automatic applyStimulusAw(input logic [63:0] addr, input logic [7:0] len);
    int n = 0;
    in.aw = '0; in.aw.addr = addr; in.aw.len = len; in.awvalid = 1'b1;
    awQ.push_back(addr);
    while (!inFb.awready && n < 20) begin tick(); n++; end
    checkOutput("awAccept", 64'(inFb.awready), 64'd1);
    tick();
    in.awvalid = 1'b0;
  endtask

  task automatic applyStimulusW(input logic [63:0] data, input logic last);
    int n = 0;
    in.w = '0; in.w.data = {192'd0, data}; in.w.strb = '1; in.w.last = last; in.wvalid = 1'b1;
    wQ.push_back(data);
    while (!inFb.wready && n < 20) begin tick(); n++; end
    checkOutput("wAccept", 64'(inFb.wready), 64'd1);
    tick();
    in.wvalid = 1'b0;
  endtask

  task automatic applyStimulusR(input logic [63:0] data, input logic last);
    outFb.r = '0; outFb.r.data = {192'd0, data}; outFb.r.last = last; outFb.rvalid = 1'b1;
    rQ.push_back({last, data});
    tick();
    outFb.rvalid = 1'b0;
  endtask

  task automatic applyStimulusB(input logic [3:0] id);
    outFb.b = '0; outFb.b.id = id; outFb.bvalid = 1'b1;
    bQ.push_back(64'(id));
    tick();
    outFb.bvalid = 1'b0;
  endtask

  // Handshakes sampled at the falling edge resolve at the following rising edge.
  always @(negedge clock) begin
    if (out.arvalid && outFb.arready) begin
      checkOutput("arPending", 64'(arQ.size() > 0), 64'd1);
      if (arQ.size() > 0) checkOutput("arAddr", out.ar.addr, arQ.pop_front());
    end
    if (out.awvalid && outFb.awready) begin
      checkOutput("awPending", 64'(awQ.size() > 0), 64'd1);
      if (awQ.size() > 0) checkOutput("awAddr", out.aw.addr, awQ.pop_front());
    end
    if (out.wvalid && outFb.wready) begin
      checkOutput("wPending", 64'(wQ.size() > 0), 64'd1);
      if (wQ.size() > 0) checkOutput("wData", out.w.data[63:0], wQ.pop_front());
    end
    if (inFb.rvalid && in.rready) begin
      checkOutput("rPending", 64'(rQ.size() > 0), 64'd1);
      if (rQ.size() > 0) begin
        rExp = rQ.pop_front();
        checkOutput("rData", inFb.r.data[63:0], rExp[63:0]);
        checkOutput("rLast", 64'(inFb.r.last), 64'(rExp[64]));
      end
    end
    if (inFb.bvalid && in.bready) begin
      checkOutput("bPending", 64'(bQ.size() > 0), 64'd1);
      if (bQ.size() > 0) checkOutput("bId", 64'(inFb.b.id), bQ.pop_front());
    end
  end

  initial begin
    in = '0;
    outFb = '0;
    in.bready = 1'b1;
    reset = 1'b0;
    ticks(3);

    // Reset state
    checkOutput("rstRCredits", 64'(rCredits), 64'(RDepth));
    checkOutput("rstWrOut", 64'(wrOutstanding), 64'd0);
    checkOutput("rstRdOut", 64'(rdOutstanding), 64'd0);
    checkOutput("rstWBursts", 64'(wBursts), 64'd0);
    checkOutput("rstArValid", 64'(out.arvalid), 64'd0);
    checkOutput("rstArReady", 64'(inFb.arready), 64'd0);
    checkOutput("rstRReady", 64'(out.rready), 64'd1);
    checkOutput("rstBReady", 64'(out.bready), 64'd1);
    reset = 1'b1;
    ticks(3);
    checkOutput("postRstArReady", 64'(inFb.arready), 64'd1);

    // Write gating: AW waits for its complete W burst
    applyStimulusAw(64'h1000, 8'd3);
    checkOutput("awGatedNoW", 64'(out.awvalid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulusW(64'hB000 + 64'(i), 1'b0);
      checkOutput("awGatedPartialW", 64'(out.awvalid), 64'd0);
    end
    applyStimulusW(64'hB003, 1'b1);
    checkOutput("awAfterWlast", 64'(out.awvalid), 64'd1);
    checkOutput("wBurstsOne", 64'(wBursts), 64'd1);
    outFb.awready = 1'b1;
    outFb.wready = 1'b1;
    tick();
    outFb.awready = 1'b0;
    checkOutput("wrOutAfterAw", 64'(wrOutstanding), 64'd1);
    checkOutput("wBurstsAfterAw", 64'(wBursts), 64'd0);
    ticks(4);
    applyStimulusB(4'd5);
    tick();
    checkOutput("wrOutAfterB", 64'(wrOutstanding), 64'd0);

    // Outstanding write cap of two
    outFb.awready = 1'b1;
    applyStimulusAw(64'h2000, 8'd0);
    applyStimulusAw(64'h2100, 8'd0);
    applyStimulusAw(64'h2200, 8'd0);
    for (int i = 0; i < 3; i++) applyStimulusW(64'hC000 + 64'(i), 1'b1);
    ticks(6);
    checkOutput("capWrOut", 64'(wrOutstanding), 64'd2);
    checkOutput("capAwStalled", 64'(out.awvalid), 64'd0);
    checkOutput("capWBursts", 64'(wBursts), 64'd1);
    applyStimulusB(4'd1);
    tick();
    checkOutput("capWrOutAfterB", 64'(wrOutstanding), 64'd1);
    checkOutput("capAwReleased", 64'(out.awvalid), 64'd1);
    tick();
    checkOutput("capWrOutRefill", 64'(wrOutstanding), 64'd2);
    checkOutput("capWBurstsDone", 64'(wBursts), 64'd0);
    outFb.awready = 1'b0;
    applyStimulusB(4'd2);
    applyStimulusB(4'd3);
    ticks(3);
    checkOutput("capWrOutDrained", 64'(wrOutstanding), 64'd0);

    // Read credit: 16-beat read consumes all credit, next AR waits for one beat
    outFb.arready = 1'b1;
    in.rready = 1'b0;
    applyStimulusAr(64'h3000, 8'd15);
    applyStimulusAr(64'h3100, 8'd0);
    ticks(2);
    checkOutput("credZero", 64'(rCredits), 64'd0);
    checkOutput("credArStalled", 64'(out.arvalid), 64'd0);
    checkOutput("credRdOut", 64'(rdOutstanding), 64'd1);
    for (int i = 0; i < 16; i++) applyStimulusR(64'hD000 + 64'(i), (i == 15));
    checkOutput("credRBuffered", 64'(inFb.rvalid), 64'd1);
    checkOutput("credStillZero", 64'(rCredits), 64'd0);
    in.rready = 1'b1;
    tick();
    in.rready = 1'b0;
    checkOutput("credOne", 64'(rCredits), 64'd1);
    checkOutput("credArReleased", 64'(out.arvalid), 64'd1);
    tick();
    checkOutput("credZeroAgain", 64'(rCredits), 64'd0);
    checkOutput("credRdOutTwo", 64'(rdOutstanding), 64'd2);
    applyStimulusR(64'hD100, 1'b1);
    in.rready = 1'b1;
    ticks(20);
    in.rready = 1'b0;
    checkOutput("credRestored", 64'(rCredits), 64'(RDepth));
    checkOutput("credRdOutZero", 64'(rdOutstanding), 64'd0);

    // Reserve and return in the same cycle
    applyStimulusAr(64'h4000, 8'd7);
    tick();
    checkOutput("simCredEight", 64'(rCredits), 64'd8);
    for (int i = 0; i < 8; i++) applyStimulusR(64'hE000 + 64'(i), (i == 7));
    outFb.arready = 1'b0;
    applyStimulusAr(64'h4100, 8'd3);
    checkOutput("simCredHeld", 64'(rCredits), 64'd8);
    checkOutput("simArValid", 64'(out.arvalid), 64'd1);
    outFb.arready = 1'b1;
    in.rready = 1'b1;
    tick();
    outFb.arready = 1'b0;
    in.rready = 1'b0;
    checkOutput("simCredFive", 64'(rCredits), 64'd5);
    checkOutput("simRdOut", 64'(rdOutstanding), 64'd2);
    for (int i = 0; i < 4; i++) applyStimulusR(64'hE100 + 64'(i), (i == 3));
    in.rready = 1'b1;
    ticks(16);
    in.rready = 1'b0;
    checkOutput("simCredRestored", 64'(rCredits), 64'(RDepth));
    checkOutput("simRdOutZero", 64'(rdOutstanding), 64'd0);

    // Reset in the middle of a read burst
    outFb.arready = 1'b1;
    applyStimulusAr(64'h5000, 8'd7);
    tick();
    for (int i = 0; i < 3; i++) applyStimulusR(64'hF000 + 64'(i), 1'b0);
    reset = 1'b0;
    #1;
    rQ.delete();
    checkOutput("midRstArValid", 64'(out.arvalid), 64'd0);
    checkOutput("midRstRValid", 64'(inFb.rvalid), 64'd0);
    checkOutput("midRstArReady", 64'(inFb.arready), 64'd0);
    checkOutput("midRstCredits", 64'(rCredits), 64'(RDepth));
    checkOutput("midRstRdOut", 64'(rdOutstanding), 64'd0);
    checkOutput("midRstRReady", 64'(out.rready), 64'd1);
    ticks(2);
    reset = 1'b1;
    ticks(3);
    applyStimulusAr(64'h5100, 8'd1);
    tick();
    checkOutput("postRstCredits", 64'(rCredits), 64'(RDepth - 2));
    applyStimulusR(64'hF100, 1'b0);
    applyStimulusR(64'hF101, 1'b1);
    in.rready = 1'b1;
    ticks(6);
    in.rready = 1'b0;
    checkOutput("postRstCredRestored", 64'(rCredits), 64'(RDepth));
    checkOutput("postRstRdOut", 64'(rdOutstanding), 64'd0);

    // StoreForward=0 forwards AW without any W data
    outFb.awready = 1'b0;
    applyStimulusAw(64'h6000, 8'd0);
    checkOutput("noSfAwValid", 64'(out2.awvalid), 64'd1);
    checkOutput("noSfAwAddr", out2.aw.addr, 64'h6000);
    checkOutput("sfAwHeld", 64'(out.awvalid), 64'd0);
    // This AW is deliberately never issued by the store-and-forward instance.
    awQ.delete();

    checkOutput("arQueueDrained", 64'(arQ.size()), 64'd0);
    checkOutput("wQueueDrained", 64'(wQ.size()), 64'd0);
    checkOutput("rQueueDrained", 64'(rQ.size()), 64'd0);
    checkOutput("bQueueDrained", 64'(bQ.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertionCount, failCount);
    $finish;
  end

endmodule
